// File: rtl/maximas_pkg.sv
// maximas_pkg: shared definitions for the spectral maxima store and the
// binary search that reads it.
//   MAXIMAS_DEPTH : number of maxima entries (power of 2)
//   ENTRY_W       : entry width, {bin tag, magnitude}
//   MAG_W         : magnitude field width, low bits of an entry, used for ordering
`timescale 1ns/1ps
package maximas_pkg;

    localparam int unsigned MAXIMAS_DEPTH = 16;
    localparam int unsigned ENTRY_W       = 25;
    localparam int unsigned MAG_W         = 16;
    localparam int unsigned IDX_W         = $clog2(MAXIMAS_DEPTH);

    // Full count value; count is one bit wider than an index.
    localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W + 1)'(MAXIMAS_DEPTH);

    typedef logic [ENTRY_W-1:0] entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DUMP
    } store_state_t;

endpackage

// File: rtl/maximas_store_if.sv
// maximas_store_if: insert request channel and readout stream of the maxima store.
//   insert_valid/insert_ready : insert handshake (client -> store)
//   insert_index/insert_value : target slot (0 = largest) and entry to insert
//   insert_done               : one-cycle pulse when the write has landed
//   dump_start                : request a readout of all valid entries
//   out_valid/out_ready       : readout handshake (store -> client)
//   out_data/out_last         : readout beat and final-beat marker
// Modports: master = client side, slave = the store.
`timescale 1ns/1ps
interface maximas_store_if
    import maximas_pkg::*;
();

    logic             insert_valid;
    logic             insert_ready;
    logic [IDX_W-1:0] insert_index;
    entry_t           insert_value;
    logic             insert_done;
    logic             dump_start;
    logic             out_valid;
    logic             out_ready;
    entry_t           out_data;
    logic             out_last;

    modport master (
        output insert_valid, insert_index, insert_value, dump_start, out_ready,
        input  insert_ready, insert_done, out_valid, out_data, out_last
    );

    modport slave (
        input  insert_valid, insert_index, insert_value, dump_start, out_ready,
        output insert_ready, insert_done, out_valid, out_data, out_last
    );

endinterface

// File: rtl/maximas_store.sv
// maximas_store: owns the descending-sorted array of spectral maxima. Inserts at a
// caller-supplied index by shifting entries down one slot per cycle (tail dropped),
// and streams the array out over a valid/ready handshake.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero array and count (honoured when idle)
//   bus        : maximas_store_if.slave, insert channel and readout stream
//   maximas    : registered entry array, index 0 = largest magnitude
//   count      : number of valid entries, saturates at MAXIMAS_DEPTH
// Build option: define MAXIMAS_DEDUP_EN to drop an insert whose value already sits
// in the target slot (array and count untouched, insert_done right after accept).
`timescale 1ns/1ps
module maximas_store
    import maximas_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    maximas_store_if.slave bus,
    output entry_t         maximas [MAXIMAS_DEPTH-1:0],
    output logic [IDX_W:0] count
);

    store_state_t     state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] idx_q;
    entry_t           value_q;
    logic [IDX_W-1:0] rd_ptr_q;
    logic             done_q;
    logic             is_dup;

`ifdef MAXIMAS_DEDUP_EN
    // Full-width match against the slot being targeted; tag bits included.
    assign is_dup = (count != '0) && (bus.insert_value == maximas[bus.insert_index]);
`else
    assign is_dup = 1'b0;
`endif

    assign bus.insert_ready = (state_q == S_IDLE);
    assign bus.insert_done  = done_q;
    assign bus.out_valid    = (state_q == S_DUMP);
    // Array and rd_ptr are frozen during a stall, so out_data holds by construction.
    assign bus.out_data     = maximas[rd_ptr_q];
    assign bus.out_last     = (state_q == S_DUMP) && ({1'b0, rd_ptr_q} == count - 1'b1);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAXIMAS_DEPTH; i++) begin
                maximas[i] <= '0;
            end
            count    <= '0;
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            value_q  <= '0;
            rd_ptr_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.insert_valid) begin
                        idx_q   <= bus.insert_index;
                        value_q <= bus.insert_value;
                        ptr_q   <= IDX_W'(MAXIMAS_DEPTH - 1);
                        if (is_dup) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_SHIFT;
                        end
                    end else if (clear) begin
                        for (int i = 0; i < MAXIMAS_DEPTH; i++) begin
                            maximas[i] <= '0;
                        end
                        count <= '0;
                    end else if (bus.dump_start && (count != '0)) begin
                        rd_ptr_q <= '0;
                        state_q  <= S_DUMP;
                    end
                end
                S_SHIFT: begin
                    if (ptr_q == idx_q) begin
                        maximas[idx_q] <= value_q;
                        count          <= (count == DEPTH_CNT) ? DEPTH_CNT : count + 1'b1;
                        done_q         <= 1'b1;
                        state_q        <= S_IDLE;
                    end else begin
                        // Walk from the tail upward; the old tail is overwritten first.
                        maximas[ptr_q] <= maximas[ptr_q - 1'b1];
                        ptr_q          <= ptr_q - 1'b1;
                    end
                end
                S_DUMP: begin
                    if (bus.out_ready) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        if (bus.out_last) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maximas_store.sv
// tb_maximas_store: directed self-checking bench for maximas_store.
`timescale 1ns/1ps
module tb_maximas_store;
    import maximas_pkg::*;

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic           clear = 1'b0;
    entry_t         maximas [MAXIMAS_DEPTH-1:0];
    logic [IDX_W:0] count;

    entry_t model [MAXIMAS_DEPTH];
    int     model_count = 0;
    int     n_assert    = 0;
    int     n_fail      = 0;

    maximas_store_if bus ();

    maximas_store dut (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .bus     (bus),
        .maximas (maximas),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic entry_t mk(input int tag, input int mag);
        entry_t e;
        e = '0;
        e[ENTRY_W-1:MAG_W] = tag[ENTRY_W-MAG_W-1:0];
        e[MAG_W-1:0]       = mag[MAG_W-1:0];
        return e;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < MAXIMAS_DEPTH; i++) model[i] = '0;
        model_count = 0;
    endfunction

    function automatic void model_insert(input int idx, input entry_t v);
        for (int i = MAXIMAS_DEPTH - 1; i > idx; i--) model[i] = model[i-1];
        model[idx] = v;
        if (model_count < MAXIMAS_DEPTH) model_count++;
    endfunction

    task automatic check_array(input string tag);
        for (int i = 0; i < MAXIMAS_DEPTH; i++)
            check($sformatf("%s maximas[%0d]", tag, i), maximas[i], model[i]);
        check({tag, " count"}, count, model_count);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    // Latency is counted in cycles after the accept edge; 0 means insert_done
    // is already high right after that edge.
    task automatic do_insert(input string tag, input int idx, input entry_t v,
                             input int exp_lat);
        int lat;
        for (int c = 0; c < 40 && !bus.insert_ready; c++) tick();
        check({tag, " ready before accept"}, bus.insert_ready, 1);
        bus.insert_valid = 1'b1;
        bus.insert_index = idx[IDX_W-1:0];
        bus.insert_value = v;
        tick();
        bus.insert_valid = 1'b0;
        lat = -1;
        for (int c = 0; c <= 40; c++) begin
            if (bus.insert_done) begin
                lat = c;
                break;
            end
            tick();
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " ready with done"}, bus.insert_ready, 1);
    endtask

    initial begin
        int    beat;
        int    done_seen;
        bit    pat [4];
        bus.insert_valid = 1'b0;
        bus.insert_index = '0;
        bus.insert_value = '0;
        bus.dump_start   = 1'b0;
        bus.out_ready    = 1'b0;

        // Reset state
        do_reset();
        check_array("reset");
        check("reset insert_ready", bus.insert_ready, 1);
        check("reset insert_done", bus.insert_done, 0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset out_last", bus.out_last, 0);

        // Single insert at idx 0: 16 cycles
        do_insert("ins0", 0, 25'h000_0100, 16);
        check("ins0 maximas[0]", maximas[0], 25'h000_0100);
        check("ins0 count", count, 1);
        tick();
        check("ins0 done is a pulse", bus.insert_done, 0);

        // Mid-array insert: 0x500, 0x300, 0x100, then 0x400 at idx 1
        do_reset();
        do_insert("mid a", 0, mk(1, 'h500), 16);
        do_insert("mid b", 1, mk(2, 'h300), 15);
        do_insert("mid c", 2, mk(3, 'h100), 14);
        do_insert("mid d", 1, mk(10, 'h400), 15);
        check("mid [0]", maximas[0], mk(1, 'h500));
        check("mid [1]", maximas[1], mk(10, 'h400));
        check("mid [2]", maximas[2], mk(2, 'h300));
        check("mid [3]", maximas[3], mk(3, 'h100));
        check("mid [4]", maximas[4], 0);
        check("mid count", count, 4);

        // Fill to 16 by appending (idx == count), then full-array inserts
        do_reset();
        for (int i = 0; i < MAXIMAS_DEPTH; i++) begin
            do_insert($sformatf("fill %0d", i), i, mk(i, (16 - i) * 'h10), 16 - i);
            model_insert(i, mk(i, (16 - i) * 'h10));
        end
        check_array("fill");
        do_insert("tail15", 15, mk('h1ff, 'h8), 1);
        model_insert(15, mk('h1ff, 'h8));
        check("tail15 [15]", maximas[15], mk('h1ff, 'h8));
        check("tail15 count", count, 16);
        do_insert("head0", 0, mk('h77, 'h200), 16);
        model_insert(0, mk('h77, 'h200));
        check("head0 [15] is old [14]", maximas[15], mk(14, 'h20));
        check_array("head0");

        // Duplicate of the entry already at idx 3
`ifdef MAXIMAS_DEDUP_EN
        do_insert("dup", 3, model[3], 0);
`else
        do_insert("dup", 3, model[3], 13);
        model_insert(3, model[3]);
`endif
        check_array("dup");

        // Clear
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_reset();
        check_array("clear");
        check("clear insert_ready", bus.insert_ready, 1);

        // Dump with count 0 produces nothing
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        check("dump0 out_valid", bus.out_valid, 0);
        check("dump0 insert_ready", bus.insert_ready, 1);

        // Dump with count 3, out_ready 1,0,1,1
        do_insert("dmp a", 0, mk(4, 'h900), 16);
        do_insert("dmp b", 1, mk(5, 'h600), 15);
        do_insert("dmp c", 2, mk(6, 'h050), 14);
        tick();
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
        beat = 0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("dump step%0d out_valid", k), bus.out_valid, 1);
            check($sformatf("dump step%0d out_data", k), bus.out_data,
                  (beat == 0) ? mk(4, 'h900) : (beat == 1) ? mk(5, 'h600) : mk(6, 'h050));
            check($sformatf("dump step%0d out_last", k), bus.out_last, (beat == 2) ? 1 : 0);
            check($sformatf("dump step%0d insert_ready", k), bus.insert_ready, 0);
            bus.out_ready = pat[k];
            tick();
            if (pat[k]) beat++;
        end
        bus.out_ready = 1'b0;
        check("dump end out_valid", bus.out_valid, 0);
        check("dump end insert_ready", bus.insert_ready, 1);

        // Reset during the shift of an idx 0 insert
        bus.insert_valid = 1'b1;
        bus.insert_index = '0;
        bus.insert_value = mk(7, 'hfff);
        tick();
        bus.insert_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("midrst shifting", bus.insert_ready, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check_array("midrst");
        check("midrst insert_ready", bus.insert_ready, 1);
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.insert_done) done_seen = 1;
            tick();
        end
        check("midrst no done pulse", done_seen, 0);
        check_array("midrst later");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
